// File: rtl/eviction_policy_engine_if.sv
// Update and victim-request bundle between the cache controller (master) and the
// eviction policy engine (slave).
interface eviction_policy_engine_if #(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 16
);
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;

    logic                hit;
    logic [SET_W-1:0]    hitSet;
    logic [NUM_WAYS-1:0] hitWay;
    logic                allocate;
    logic [SET_W-1:0]    allocateSet;
    logic [NUM_WAYS-1:0] allocateWay;
    logic                invalidate;
    logic [SET_W-1:0]    invalidateSet;
    logic [NUM_WAYS-1:0] invalidateWay;
    logic                evictReq;
    logic [SET_W-1:0]    evictSet;
    logic [NUM_WAYS-1:0] evictionTarget;
    logic                evictionReady;
    logic                busy;
    logic                dropped;

    modport master (
        output hit, hitSet, hitWay,
        output allocate, allocateSet, allocateWay,
        output invalidate, invalidateSet, invalidateWay,
        output evictReq, evictSet,
        input  evictionTarget, evictionReady, busy, dropped
    );

    modport slave (
        input  hit, hitSet, hitWay,
        input  allocate, allocateSet, allocateWay,
        input  invalidate, invalidateSet, invalidateWay,
        input  evictReq, evictSet,
        output evictionTarget, evictionReady, busy, dropped
    );
endinterface

// File: rtl/eviction_policy_engine.sv
// Per-set LRU/FIFO replacement engine: one update per cycle, victim ready two cycles
// after an accepted request; requests are ignored while busy and must be held.
module eviction_policy_engine #(
    parameter  int NUM_WAYS = 8,
    parameter  int NUM_SETS = 16,
    parameter  int POLICY   = 0,
    localparam int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    eviction_policy_engine_if.slave  bus
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef logic [WAY_W-1:0] age_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    localparam age_t AGE_MAX = age_t'(NUM_WAYS - 1);
    localparam age_t AGE_ONE = age_t'(1);

    age_t                age_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];

    state_t              state_q;
    logic [SET_W-1:0]    evict_set_q;
    logic [NUM_WAYS-1:0] target_q;
    logic                ready_q;
    logic                busy_q;
    logic                dropped_q;

    logic [SET_W-1:0]    upd_set;
    logic [NUM_WAYS-1:0] upd_vec;
    logic                vec_ok;
    logic                do_touch;
    logic                do_inval;
    logic                do_alloc;
    logic                dropped_d;
    age_t                ref_age;
    age_t                cur_age;
    age_t                set_age_d [NUM_WAYS];
    logic [NUM_WAYS-1:0] set_valid_d;
    logic [NUM_WAYS-1:0] victim_d;
    logic                found_invalid;

    function automatic age_t way_idx(input logic [NUM_WAYS-1:0] v);
        age_t idx;
        idx = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (v[w]) idx = age_t'(w);
        end
        return idx;
    endfunction

    // Strobe arbitration: the highest-priority strobe owns the cycle even when its
    // way vector turns out to be malformed; everything below it is discarded.
    always_comb begin
        upd_set   = '0;
        upd_vec   = '0;
        vec_ok    = 1'b0;
        do_touch  = 1'b0;
        do_inval  = 1'b0;
        do_alloc  = 1'b0;
        dropped_d = (bus.allocate && (bus.hit || bus.invalidate)) ||
                    (bus.hit && bus.invalidate);
        if (bus.allocate) begin
            upd_set  = bus.allocateSet;
            upd_vec  = bus.allocateWay;
            vec_ok   = ($countones(bus.allocateWay) == 1);
            do_alloc = vec_ok;
            do_touch = vec_ok;
        end else if (bus.hit) begin
            upd_set  = bus.hitSet;
            upd_vec  = bus.hitWay;
            vec_ok   = ($countones(bus.hitWay) == 1);
            do_touch = vec_ok && (POLICY == 0);
        end else if (bus.invalidate) begin
            upd_set  = bus.invalidateSet;
            upd_vec  = bus.invalidateWay;
            vec_ok   = ($countones(bus.invalidateWay) == 1);
            do_inval = vec_ok;
        end
        if ((bus.allocate || bus.hit || bus.invalidate) && !vec_ok) dropped_d = 1'b1;
    end

    // Next recency state of the addressed set; keeps the ages a permutation.
    always_comb begin
        ref_age     = age_q[upd_set][way_idx(upd_vec)];
        cur_age     = '0;
        set_valid_d = valid_q[upd_set];
        if (do_alloc) set_valid_d = set_valid_d | upd_vec;
        if (do_inval) set_valid_d = set_valid_d & ~upd_vec;
        for (int w = 0; w < NUM_WAYS; w++) begin
            cur_age      = age_q[upd_set][w];
            set_age_d[w] = cur_age;
            if (upd_vec[w]) begin
                if (do_touch)      set_age_d[w] = '0;
                else if (do_inval) set_age_d[w] = AGE_MAX;
            end else if (do_touch && (cur_age < ref_age)) begin
                set_age_d[w] = cur_age + AGE_ONE;
            end else if (do_inval && (cur_age > ref_age)) begin
                set_age_d[w] = cur_age - AGE_ONE;
            end
        end
    end

    always_comb begin
        victim_d      = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid_q[evict_set_q][w] && !found_invalid) begin
                victim_d[w]   = 1'b1;
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[evict_set_q][w] == AGE_MAX) victim_d[w] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            evict_set_q <= '0;
            target_q    <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= age_t'(w);
                end
            end
        end else begin
            dropped_q <= dropped_d;
            if (do_touch || do_inval) begin
                valid_q[upd_set] <= set_valid_d;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[upd_set][w] <= set_age_d[w];
                end
            end
            case (state_q)
                IDLE: begin
                    target_q <= '0;
                    ready_q  <= 1'b0;
                    if (bus.evictReq) begin
                        evict_set_q <= bus.evictSet;
                        busy_q      <= 1'b1;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    target_q <= victim_d;
                    ready_q  <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    target_q <= '0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    target_q <= '0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.evictionTarget = target_q;
    assign bus.evictionReady  = ready_q;
    assign bus.busy           = busy_q;
    assign bus.dropped        = dropped_q;
endmodule
